// File: rtl/clk_switch_sequencer.sv
// Sequences clock-mux select, clock wizard enable and core reset around select changes and lock loss.
// Optional: define CLKSEQ_LOCK_RETRY_EN to retry SETTLE twice on lock timeout before entering FAULT.
module clk_switch_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned DRAIN_CYCLES    = 64,
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT    = 65535,
  parameter int unsigned RELEASE_CYCLES  = 32,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       sel_req,
  input  logic       locked,
  input  logic       fault_clear,
  output logic       clk_sel,
  output logic       clk_wiz_enable,
  output logic       core_reset_n,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] SETTLE   = 3'd0;
  localparam logic [2:0] LOCKWAIT = 3'd1;
  localparam logic [2:0] RELEASE  = 3'd2;
  localparam logic [2:0] RUN      = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;
  localparam logic [2:0] SWITCH   = 3'd5;
  localparam logic [2:0] FAULT    = 3'd6;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(RELEASE_CYCLES - 1);

  logic             sel_meta, sel_s, lock_meta, locked_s;
  logic             sel_stable;
  logic [CNT_W-1:0] deb_cnt, cnt;
  logic [2:0]       state_n;
  logic             wiz_n, crn_n, csel_n;
`ifdef CLKSEQ_LOCK_RETRY_EN
  logic [1:0]       retry_cnt, retry_n;
`endif

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      sel_meta   <= 1'b0;
      sel_s      <= 1'b0;
      lock_meta  <= 1'b0;
      locked_s   <= 1'b0;
      sel_stable <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      sel_meta  <= sel_req;
      sel_s     <= sel_meta;
      lock_meta <= locked;
      locked_s  <= lock_meta;
      if (sel_s == sel_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        sel_stable <= sel_s;
        deb_cnt    <= '0;
      end else if (deb_cnt != '1) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    wiz_n   = clk_wiz_enable;
    crn_n   = core_reset_n;
    csel_n  = clk_sel;
`ifdef CLKSEQ_LOCK_RETRY_EN
    retry_n = retry_cnt;
`endif
    case (state)
      SETTLE: begin
        wiz_n = 1'b0;
        crn_n = 1'b0;
        if (cnt == SETTLE_LAST) begin
          state_n = LOCKWAIT;
          wiz_n   = 1'b1;
        end
      end
      LOCKWAIT: begin
        crn_n = 1'b0;
        if (locked_s) begin
          state_n = RELEASE;
        end else if (cnt == LOCK_LAST) begin
          wiz_n = 1'b0;
`ifdef CLKSEQ_LOCK_RETRY_EN
          if (retry_cnt != 2'd2) begin
            retry_n = retry_cnt + 2'd1;
            state_n = SETTLE;
          end else begin
            state_n = FAULT;
          end
`else
          state_n = FAULT;
`endif
        end
      end
      RELEASE: begin
        crn_n = 1'b0;
        if (!locked_s) begin
          state_n = LOCKWAIT;
        end else if (cnt == REL_LAST) begin
          state_n = RUN;
          crn_n   = 1'b1;
        end
      end
      RUN: begin
        // Lock loss outranks a pending select change.
        if (!locked_s) begin
          state_n = LOCKWAIT;
          crn_n   = 1'b0;
        end else if (sel_stable != clk_sel) begin
          state_n = DRAIN;
          crn_n   = 1'b0;
        end
      end
      DRAIN: begin
        crn_n = 1'b0;
        if (cnt == DRAIN_LAST) begin
          state_n = SWITCH;
          wiz_n   = 1'b0;
        end
      end
      SWITCH: begin
        wiz_n   = 1'b0;
        crn_n   = 1'b0;
        csel_n  = sel_stable;
        state_n = SETTLE;
      end
      FAULT: begin
        wiz_n = 1'b0;
        crn_n = 1'b0;
        if (fault_clear) begin
          state_n = SWITCH;
`ifdef CLKSEQ_LOCK_RETRY_EN
          retry_n = '0;
`endif
        end
      end
      default: begin
        state_n = SETTLE;
        wiz_n   = 1'b0;
        crn_n   = 1'b0;
      end
    endcase
`ifdef CLKSEQ_LOCK_RETRY_EN
    if (state_n == RUN && state != RUN) retry_n = '0;
`endif
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state          <= SETTLE;
      cnt            <= '0;
      clk_sel        <= 1'b0;
      clk_wiz_enable <= 1'b0;
      core_reset_n   <= 1'b0;
      busy           <= 1'b1;
      fault          <= 1'b0;
`ifdef CLKSEQ_LOCK_RETRY_EN
      retry_cnt      <= '0;
`endif
    end else begin
      state          <= state_n;
      clk_sel        <= csel_n;
      clk_wiz_enable <= wiz_n;
      core_reset_n   <= crn_n;
      busy           <= (state_n != RUN);
      fault          <= (state_n == FAULT);
`ifdef CLKSEQ_LOCK_RETRY_EN
      retry_cnt      <= retry_n;
`endif
      if (state_n != state) cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_switch_sequencer.sv
// Directed bench for clk_switch_sequencer: cycle table for bring-up, glitch and select change,
// plus hand sequences for lock timeout/fault, lock drop and reset (retry build via CLKSEQ_LOCK_RETRY_EN).
module tb_clk_switch_sequencer;

  logic       sys_clock = 1'b0;
  logic       reset, sel_req, locked, fault_clear;
  logic       clk_sel, clk_wiz_enable, core_reset_n, busy, fault;
  logic [2:0] state;
  logic [7:0] obs;

  clk_switch_sequencer #(
    .DEBOUNCE_CYCLES(8),
    .DRAIN_CYCLES(4),
    .SETTLE_CYCLES(3),
    .LOCK_TIMEOUT(20),
    .RELEASE_CYCLES(5),
    .CNT_W(16)
  ) dut (
    .sys_clock(sys_clock),
    .reset(reset),
    .sel_req(sel_req),
    .locked(locked),
    .fault_clear(fault_clear),
    .clk_sel(clk_sel),
    .clk_wiz_enable(clk_wiz_enable),
    .core_reset_n(core_reset_n),
    .busy(busy),
    .fault(fault),
    .state(state)
  );

  always #5 sys_clock = ~sys_clock;

  assign obs = {state, clk_wiz_enable, core_reset_n, busy, fault, clk_sel};

  // flags = {clk_wiz_enable, core_reset_n, busy, fault, clk_sel}
  typedef struct {
    logic       sel;
    logic       lk;
    logic       fc;
    logic [2:0] st;
    logic [4:0] flags;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

`ifdef CLKSEQ_LOCK_RETRY_EN
  localparam int EXP_LW = 60;
  localparam int EXP_SE = 2;
`else
  localparam int EXP_LW = 20;
  localparam int EXP_SE = 0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clock);
  endtask

  function automatic void add(input int n, input logic s, input logic lk, input logic fc,
                              input logic [2:0] st, input logic [4:0] flags);
    for (int k = 0; k < n; k++) vecs.push_back('{s, lk, fc, st, flags});
  endfunction

  initial begin
    int lw, se, n;
    logic [2:0] prev;

    // Entry k: inputs driven before edge k after reset release, outputs expected after edge k.
    add(2,  1'b0, 1'b1, 1'b0, 3'd0, 5'b00100);  // SETTLE
    add(1,  1'b0, 1'b1, 1'b0, 3'd1, 5'b10100);  // LOCKWAIT, wizard on
    add(5,  1'b0, 1'b1, 1'b0, 3'd2, 5'b10100);  // RELEASE
    add(2,  1'b0, 1'b1, 1'b0, 3'd3, 5'b11000);  // RUN
    add(5,  1'b1, 1'b1, 1'b0, 3'd3, 5'b11000);  // 5-cycle glitch ignored
    add(12, 1'b0, 1'b1, 1'b0, 3'd3, 5'b11000);
    // Steady select: 2 sync + 8 debounce edges accept it, RUN reacts on the 11th edge.
    add(10, 1'b1, 1'b1, 1'b0, 3'd3, 5'b11000);
    add(4,  1'b1, 1'b1, 1'b0, 3'd4, 5'b10100);  // DRAIN
    add(1,  1'b1, 1'b1, 1'b0, 3'd5, 5'b00100);  // SWITCH, wizard off
    add(3,  1'b1, 1'b1, 1'b0, 3'd0, 5'b00101);  // SETTLE, clk_sel=1
    add(1,  1'b1, 1'b1, 1'b0, 3'd1, 5'b10101);
    add(5,  1'b1, 1'b1, 1'b0, 3'd2, 5'b10101);
    add(2,  1'b1, 1'b1, 1'b0, 3'd3, 5'b11001);

    reset = 1'b1; sel_req = 1'b0; locked = 1'b1; fault_clear = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", int'(obs), int'(8'b000_00100));
    reset = 1'b0;

    foreach (vecs[i]) begin
      sel_req     = vecs[i].sel;
      locked      = vecs[i].lk;
      fault_clear = vecs[i].fc;
      tick();
      chk($sformatf("vec%0d", i), int'(obs), int'({vecs[i].st, vecs[i].flags}));
    end

    // Lock loss in RUN, then timeout(s) into FAULT.
    locked = 1'b0;
    lw = 0; se = 0; prev = state;
    for (int i = 0; i < 300 && state != 3'd6; i++) begin
      tick();
      if (state == 3'd1) lw++;
      if (state == 3'd0 && prev != 3'd0) se++;
      prev = state;
    end
    chk("fault_state", int'(state), 6);
    chk("lockwait_cycles", lw, EXP_LW);
    chk("settle_reentries", se, EXP_SE);
    chk("fault_flag", int'(fault), 1);
    chk("fault_wiz", int'(clk_wiz_enable), 0);
    chk("fault_core_rst", int'(core_reset_n), 0);
    repeat (4) tick();
    locked = 1'b1;
    repeat (3) tick();
    chk("fault_holds", int'({state, fault}), int'({3'd6, 1'b1}));

    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    chk("clear_to_switch", int'({state, fault}), int'({3'd5, 1'b0}));
    tick();
    chk("switch_reload_sel", int'({state, clk_sel}), int'({3'd0, 1'b1}));
    n = 0;
    for (int i = 0; i < 50 && state != 3'd3; i++) begin
      tick();
      n++;
    end
    chk("recover_cycles", n, 9);
    chk("recover_run", int'({fault, core_reset_n, busy}), int'(3'b010));

    // One-sample lock drop in RUN.
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    chk("drop_still_run", int'(state), 3);
    tick();
    chk("drop_lockwait", int'({state, core_reset_n, busy}), int'({3'd1, 1'b0, 1'b1}));
    tick();
    chk("drop_release", int'(state), 2);
    repeat (4) tick();
    chk("drop_release_end", int'({state, core_reset_n}), int'({3'd2, 1'b0}));
    tick();
    chk("drop_run", int'({state, core_reset_n, busy}), int'({3'd3, 1'b1, 1'b0}));

    // Reset from RUN restores all reset values, including clk_sel.
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("reset_from_run", int'(obs), int'(8'b000_00100));
    reset = 1'b0;
    tick();
    chk("after_reset_settle", int'(obs), int'(8'b000_00100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_switch_sequencer.md
Name: clk_switch_sequencer

Overview:
- Sequences the target's clock-source mux and clock wizard so that the core never runs across a clock change or an unlocked clock.
- Debounces the clock-select DIP switch, holds the Cortex-M3 in reset, and gates the clock wizard enable around a select change.
- Waits for MMCM lock, with timeout, then releases core reset.
- Sits in the top level between the DIP/lock inputs and the BUFGCTRL select, clk_wiz_enable and core reset AND-tree. Runs on a free-running reference clock that this block never switches.

Parameters:
DEBOUNCE_CYCLES, 1024, cycles the synchronized select must differ from the accepted value before it is accepted (min 1)
DRAIN_CYCLES, 64, cycles core reset is held before the wizard is disabled (min 1)
SETTLE_CYCLES, 16, cycles with wizard disabled after a select change or after reset (min 1)
LOCK_TIMEOUT, 65535, max cycles in LOCKWAIT before FAULT (min 1)
RELEASE_CYCLES, 32, cycles core reset is held after lock (min 1)
CNT_W, 16, phase counter width; must hold max(all cycle parameters)

Ports:
sys_clock  input  1  free-running reference clock; all logic on rising edge
reset  input  1  synchronous, active-high
sel_req  input  1  async clock-select DIP (0=pll_clk1, 1=tio_clkin)
locked  input  1  async MMCM lock from clock wizard
fault_clear  input  1  one-cycle pulse; leaves FAULT
clk_sel  output  1  to BUFGCTRL S1 (S0 = ~clk_sel)
clk_wiz_enable  output  1  clock wizard enable
core_reset_n  output  1  active-low core reset, ANDed into the core reset
busy  output  1  high in every state except RUN
fault  output  1  lock timeout occurred
state  output  3  current state encoding, for debug/LED

Behaviour:
- All outputs are registered.
- Reset values: clk_sel=0, clk_wiz_enable=0, core_reset_n=0, busy=1, fault=0, state=SETTLE. All counters and sync flops are 0; sel_stable=0.
- Synchronizers: sel_req and locked each pass through 2 flops, giving sel_s and locked_s (2-cycle latency).
- Debounce: deb_cnt clears whenever sel_s==sel_stable. Otherwise it increments. When deb_cnt reaches DEBOUNCE_CYCLES-1 while sel_s!=sel_stable, sel_stable<=sel_s and deb_cnt<=0. A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Phase counter cnt clears on every state change. A state with parameter N lasts exactly N cycles.
- Encoding: SETTLE=0, LOCKWAIT=1, RELEASE=2, RUN=3, DRAIN=4, SWITCH=5, FAULT=6.
- SETTLE:
  - clk_wiz_enable=0, core_reset_n=0.
  - After SETTLE_CYCLES cycles, go to LOCKWAIT and set clk_wiz_enable=1.
- LOCKWAIT:
  - core_reset_n=0.
  - If locked_s=1, go to RELEASE.
  - Else if cnt==LOCK_TIMEOUT-1, go to FAULT.
  - Lock wins on the same cycle as timeout.
- RELEASE:
  - core_reset_n=0.
  - If locked_s drops, return to LOCKWAIT with cnt cleared.
  - Else after RELEASE_CYCLES cycles, go to RUN with core_reset_n=1 and busy=0.
- RUN:
  - If locked_s=0, go to LOCKWAIT with core_reset_n=0 on the next edge.
  - Else if sel_stable!=clk_sel, go to DRAIN with core_reset_n=0.
  - Lock loss has priority over a select change.
- DRAIN:
  - clk_wiz_enable stays 1.
  - After DRAIN_CYCLES cycles, go to SWITCH with clk_wiz_enable=0.
- SWITCH:
  - Lasts one cycle; clk_sel<=sel_stable, then go to SETTLE.
  - The latest sel_stable is used, so select changes during DRAIN are absorbed.
- FAULT:
  - fault=1, clk_wiz_enable=0, core_reset_n=0.
  - fault_clear: fault<=0, go to SWITCH, which reloads clk_sel.
  - Select changes in FAULT are applied on exit.
- Select changes accepted in SETTLE, LOCKWAIT or RELEASE are not acted on until RUN. RUN then re-sequences.
- Reset asserted in any state: all outputs return to reset values on that edge. No in-progress sequence is resumed.
- Counters saturate; they never wrap.

Optional Feature:
CLKSEQ_LOCK_RETRY_EN:
- Defined: a 2-bit retry counter counts LOCKWAIT timeouts.
  - On the first two timeouts, the block goes to SETTLE (wizard disabled then re-enabled) instead of FAULT.
  - The third consecutive timeout goes to FAULT.
  - The retry counter clears on entering RUN, on fault_clear and on reset.
- Undefined: the first timeout goes to FAULT. No retry logic is synthesized.

Test Plan:
Use DEBOUNCE=8, DRAIN=4, SETTLE=3, LOCK_TIMEOUT=20, RELEASE=5.
- Reset with sel_req=0 and locked=1 from the start -> clk_wiz_enable rises 3 cycles after reset deasserts. core_reset_n rises 5 cycles after RELEASE entry. state=3 and busy=0.
- In RUN, pulse sel_req=1 for 5 cycles -> no state change; clk_sel stays 0.
- In RUN, set sel_req=1 steady -> DRAIN is entered 2+8 cycles later with core_reset_n=0. After 4 cycles clk_wiz_enable=0. Next cycle clk_sel=1. Then SETTLE 3 cycles, lock, RELEASE 5 cycles, and core_reset_n=1.
- Hold locked=0 -> fault=1 and state=6 after 20 LOCKWAIT cycles, with clk_wiz_enable=0. Pulse fault_clear with locked=1 -> sequence completes to RUN and fault=0.
- Drop locked for one sample in RUN -> core_reset_n=0 next edge and state=1. Restore locked -> RUN after the RELEASE cycles.
- With CLKSEQ_LOCK_RETRY_EN and locked=0 -> FAULT only after 3 timeouts, with 2 SETTLE re-entries seen on state.
